// File: rtl/store_port_responder.sv
// D$ store-port responder: grants write requests into a small in-order FIFO
// that drains one entry per memory grant, with a page-offset hazard check.
package store_port_pkg;
  localparam int unsigned XLEN               = 64;
  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 20;
  localparam int unsigned TRANS_ID_BITS      = 2;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [XLEN-1:0]               data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [XLEN/8-1:0]             data_be;
    logic [1:0]                    data_size;
    logic [TRANS_ID_BITS-1:0]      data_id;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic                     data_gnt;
    logic                     data_rvalid;
    logic [TRANS_ID_BITS-1:0] data_id;
    logic [XLEN-1:0]          data_rdata;
  } dcache_req_o_t;
endpackage

module store_port_responder
  import store_port_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       flush_i,
  input  dcache_req_i_t                              req_port_i,
  output dcache_req_o_t                              req_port_o,
  output logic                                       mem_req_o,
  input  logic                                       mem_gnt_i,
  output logic [DCACHE_TAG_WIDTH+DCACHE_INDEX_WIDTH-1:0] mem_addr_o,
  output logic [XLEN-1:0]                            mem_wdata_o,
  output logic [XLEN/8-1:0]                          mem_be_o,
  output logic [1:0]                                 mem_size_o,
  input  logic [11:0]                                page_offset_i,
  output logic                                       page_offset_matches_o,
  output logic                                       empty_o,
  output logic                                       unsupported_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned AW = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH;
  localparam int unsigned BW = XLEN / 8;
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [DEPTH-1:0][AW-1:0]   r_addr;
  logic [DEPTH-1:0][XLEN-1:0] r_wdata;
  logic [DEPTH-1:0][BW-1:0]   r_be;
  logic [DEPTH-1:0][1:0]      r_size;
  logic [DEPTH-1:0]           r_vld;
  logic [PW-1:0]              r_rd_ptr, r_wr_ptr;
  logic [PW:0]                r_cnt;
  logic                       r_rvalid, r_unsup;

  logic             w_push, w_pop, w_read;
  logic [DEPTH-1:0] w_hit;
  logic             w_unused_fields;

  // No pass-through when full: a same-cycle drain only frees space next cycle.
  assign w_push = req_port_i.data_req & req_port_i.data_we & ~flush_i & (r_cnt < CNT_FULL);
  assign w_pop  = mem_req_o & mem_gnt_i;
  assign w_read = req_port_i.data_req & ~req_port_i.data_we;

  assign w_unused_fields = ^{req_port_i.kill_req, req_port_i.tag_valid,
                             req_port_i.data_id, page_offset_i[2:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_size   <= '0;
      r_vld    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
      r_unsup  <= 1'b0;
    end else begin
      if (w_push) begin
        r_addr[r_wr_ptr]  <= {req_port_i.address_tag, req_port_i.address_index};
        r_wdata[r_wr_ptr] <= req_port_i.data_wdata;
        r_be[r_wr_ptr]    <= req_port_i.data_be;
        r_size[r_wr_ptr]  <= req_port_i.data_size;
        r_vld[r_wr_ptr]   <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      r_rvalid <= w_push;
      if (w_read) r_unsup <= 1'b1;
    end
  end

  // Per-entry page-offset comparators, qualified by entry valid.
  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
    assign w_hit[g] = r_vld[g] & (r_addr[g][11:3] == page_offset_i[11:3]);
  end

  assign page_offset_matches_o = (|w_hit) |
    (w_push & (req_port_i.address_index[11:3] == page_offset_i[11:3]));

  always_comb begin
    req_port_o             = '0;
    req_port_o.data_gnt    = w_push;
    req_port_o.data_rvalid = r_rvalid;
  end

  assign mem_req_o     = (r_cnt != '0);
  assign mem_addr_o    = r_addr[r_rd_ptr];
  assign mem_wdata_o   = r_wdata[r_rd_ptr];
  assign mem_be_o      = r_be[r_rd_ptr];
  assign mem_size_o    = r_size[r_rd_ptr];
  assign empty_o       = (r_cnt == '0);
  assign unsupported_o = r_unsup;
endmodule

// File: tb/tb_store_port_responder.sv
// Directed bench for store_port_responder (DEPTH=4): inputs driven 1 time unit
// after the rising edge, outputs sampled 1 time unit later.
module tb_store_port_responder;
  import store_port_pkg::*;

  logic          clk, rst_n, flush, mem_req, mem_gnt, match, empty, unsup;
  dcache_req_i_t req_i;
  dcache_req_o_t req_o;
  logic [31:0]   mem_addr;
  logic [63:0]   mem_wdata;
  logic [7:0]    mem_be;
  logic [1:0]    mem_size;
  logic [11:0]   page_off;
  int            n_pass = 0;
  int            n_total = 0;

  store_port_responder #(.DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_port_i(req_i), .req_port_o(req_o),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_size_o(mem_size),
    .page_offset_i(page_off), .page_offset_matches_o(match),
    .empty_o(empty), .unsupported_o(unsup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_wr(input logic [11:0] idx, input logic [63:0] d);
    req_i               = '0;
    req_i.data_req      = 1'b1;
    req_i.data_we       = 1'b1;
    req_i.address_index = idx;
    req_i.address_tag   = 20'h12;
    req_i.data_wdata    = d;
    req_i.data_be       = 8'h0F;
    req_i.data_size     = 2'd2;
  endtask

  task automatic drive_idle();
    req_i = '0;
  endtask

  task automatic test_reset();
    #3;
    n_total++; if (req_o.data_gnt !== 1'b0) $display("FAIL rst_gnt got %b exp 0", req_o.data_gnt); else n_pass++;
    n_total++; if (req_o.data_rvalid !== 1'b0) $display("FAIL rst_rvalid got %b exp 0", req_o.data_rvalid); else n_pass++;
    n_total++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req got %b exp 0", mem_req); else n_pass++;
    n_total++; if (mem_wdata !== 64'h0 || mem_addr !== 32'h0) $display("FAIL rst_mem_data got %h/%h exp 0", mem_addr, mem_wdata); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL rst_empty got %b exp 1", empty); else n_pass++;
    n_total++; if (unsup !== 1'b0 || match !== 1'b0) $display("FAIL rst_flags got unsup=%b match=%b exp 0/0", unsup, match); else n_pass++;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_store();
    tick();
    drive_wr(12'h0A8, 64'hDEADBEEF);
    mem_gnt = 1'b1;
    #1;
    n_total++; if (req_o.data_gnt !== 1'b1) $display("FAIL single_gnt got %b exp 1", req_o.data_gnt); else n_pass++;
    n_total++; if (mem_req !== 1'b0) $display("FAIL single_c0_mem_req got %b exp 0", mem_req); else n_pass++;
    tick();
    drive_idle();
    #1;
    n_total++; if (req_o.data_rvalid !== 1'b1) $display("FAIL single_rvalid got %b exp 1", req_o.data_rvalid); else n_pass++;
    n_total++; if (mem_req !== 1'b1) $display("FAIL single_c1_mem_req got %b exp 1", mem_req); else n_pass++;
    n_total++; if (mem_addr !== 32'h0001_20A8) $display("FAIL single_addr got %h exp 000120a8", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 64'hDEADBEEF || mem_be !== 8'h0F || mem_size !== 2'd2)
      $display("FAIL single_data got %h/%h/%0d exp deadbeef/0f/2", mem_wdata, mem_be, mem_size); else n_pass++;
    n_total++; if (req_o.data_rdata !== 64'h0) $display("FAIL single_rdata got %h exp 0", req_o.data_rdata); else n_pass++;
    tick();
    #1;
    n_total++; if (empty !== 1'b1 || mem_req !== 1'b0) $display("FAIL single_c2_empty got %b/%b exp 1/0", empty, mem_req); else n_pass++;
    n_total++; if (req_o.data_rvalid !== 1'b0) $display("FAIL single_rvalid_pulse got %b exp 0", req_o.data_rvalid); else n_pass++;
    mem_gnt = 1'b0;
  endtask

  task automatic test_fill_full();
    for (int k = 0; k < 5; k++) begin
      tick();
      drive_wr(12'(k * 8), 64'h100 + 64'(k));
      #1;
      n_total++; if (req_o.data_gnt !== (k < 4)) $display("FAIL fill_gnt%0d got %b exp %b", k, req_o.data_gnt, (k < 4)); else n_pass++;
    end
    n_total++; if (req_o.data_rvalid !== 1'b1 || empty !== 1'b0) $display("FAIL fill_state got rvalid=%b empty=%b exp 1/0", req_o.data_rvalid, empty); else n_pass++;
    tick();
    mem_gnt = 1'b1;
    #1;
    n_total++; if (req_o.data_gnt !== 1'b0) $display("FAIL full_no_passthru got %b exp 0", req_o.data_gnt); else n_pass++;
    n_total++; if (req_o.data_rvalid !== 1'b0) $display("FAIL full_rvalid got %b exp 0", req_o.data_rvalid); else n_pass++;
    n_total++; if (mem_req !== 1'b1 || mem_wdata !== 64'h100) $display("FAIL drain0 got %b/%h exp 1/100", mem_req, mem_wdata); else n_pass++;
    tick();
    mem_gnt = 1'b0;
    #1;
    n_total++; if (req_o.data_gnt !== 1'b1) $display("FAIL full_regrant got %b exp 1", req_o.data_gnt); else n_pass++;
    tick();
    drive_idle();
    mem_gnt = 1'b1;
    for (int k = 1; k < 5; k++) begin
      #1;
      n_total++; if (mem_req !== 1'b1 || mem_wdata !== 64'h100 + 64'(k))
        $display("FAIL drain%0d got %b/%h exp 1/%h", k, mem_req, mem_wdata, 64'h100 + 64'(k)); else n_pass++;
      if (k == 4) begin
        n_total++; if (mem_addr !== 32'h0001_2020) $display("FAIL wrap_addr got %h exp 00012020", mem_addr); else n_pass++;
      end
      tick();
    end
    #1;
    n_total++; if (empty !== 1'b1) $display("FAIL fill_drained got %b exp 1", empty); else n_pass++;
    mem_gnt = 1'b0;
  endtask

  task automatic test_push_pop();
    tick(); drive_wr(12'h010, 64'h200);
    tick(); drive_wr(12'h018, 64'h201);
    tick(); drive_wr(12'h020, 64'h202);
    mem_gnt = 1'b1;
    #1;
    n_total++; if (req_o.data_gnt !== 1'b1 || mem_wdata !== 64'h200) $display("FAIL pp_same_cycle got %b/%h exp 1/200", req_o.data_gnt, mem_wdata); else n_pass++;
    tick();
    drive_idle();
    mem_gnt = 1'b0;
    #1;
    n_total++; if (mem_wdata !== 64'h201 || empty !== 1'b0) $display("FAIL pp_head got %h/%b exp 201/0", mem_wdata, empty); else n_pass++;
    tick();
    mem_gnt = 1'b1;
    #1;
    n_total++; if (mem_wdata !== 64'h201) $display("FAIL pp_pop1 got %h exp 201", mem_wdata); else n_pass++;
    tick(); #1;
    n_total++; if (mem_wdata !== 64'h202 || mem_req !== 1'b1) $display("FAIL pp_pop2 got %h/%b exp 202/1", mem_wdata, mem_req); else n_pass++;
    tick(); #1;
    n_total++; if (empty !== 1'b1) $display("FAIL pp_count got empty=%b exp 1", empty); else n_pass++;
    mem_gnt = 1'b0;
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      tick(); drive_wr(12'h040, 64'h300 + 64'(k));
    end
    tick();
    drive_wr(12'h040, 64'h303);
    flush = 1'b1;
    mem_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_total++; if (req_o.data_gnt !== 1'b0) $display("FAIL flush_gnt%0d got %b exp 0", k, req_o.data_gnt); else n_pass++;
      if (k < 3) begin
        n_total++; if (mem_req !== 1'b1 || mem_wdata !== 64'h300 + 64'(k))
          $display("FAIL flush_drain%0d got %b/%h exp 1/%h", k, mem_req, mem_wdata, 64'h300 + 64'(k)); else n_pass++;
      end else begin
        n_total++; if (empty !== 1'b1) $display("FAIL flush_empty got %b exp 1", empty); else n_pass++;
      end
      tick();
    end
    flush = 1'b0;
    #1;
    n_total++; if (req_o.data_gnt !== 1'b1) $display("FAIL flush_resume got %b exp 1", req_o.data_gnt); else n_pass++;
    tick();
    drive_idle();
    #1;
    n_total++; if (mem_wdata !== 64'h303 || mem_req !== 1'b1) $display("FAIL flush_after got %h/%b exp 303/1", mem_wdata, mem_req); else n_pass++;
    tick();
    mem_gnt = 1'b0;
  endtask

  task automatic test_hazard();
    tick();
    drive_wr(12'h0A8, 64'h400);
    page_off = 12'h0AF;
    #1;
    n_total++; if (match !== 1'b1) $display("FAIL haz_grant got %b exp 1", match); else n_pass++;
    tick();
    drive_idle();
    #1;
    n_total++; if (match !== 1'b1) $display("FAIL haz_entry got %b exp 1", match); else n_pass++;
    page_off = 12'h0B0;
    #1;
    n_total++; if (match !== 1'b0) $display("FAIL haz_miss got %b exp 0", match); else n_pass++;
    page_off = 12'h0AF;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #1;
    n_total++; if (match !== 1'b0 || empty !== 1'b1) $display("FAIL haz_drained got %b/%b exp 0/1", match, empty); else n_pass++;
    page_off = 12'h000;
  endtask

  task automatic test_read_reset();
    tick();
    req_i          = '0;
    req_i.data_req = 1'b1;
    #1;
    n_total++; if (req_o.data_gnt !== 1'b0) $display("FAIL read_gnt got %b exp 0", req_o.data_gnt); else n_pass++;
    tick();
    drive_idle();
    #1;
    n_total++; if (req_o.data_rvalid !== 1'b0 || unsup !== 1'b1) $display("FAIL read_ack got rvalid=%b unsup=%b exp 0/1", req_o.data_rvalid, unsup); else n_pass++;
    tick(); #1;
    n_total++; if (unsup !== 1'b1) $display("FAIL read_sticky got %b exp 1", unsup); else n_pass++;
    tick(); drive_wr(12'h050, 64'h500);
    tick(); drive_wr(12'h058, 64'h501);
    tick();
    drive_idle();
    #1;
    n_total++; if (mem_req !== 1'b1 || req_o.data_rvalid !== 1'b1) $display("FAIL pre_rst got %b/%b exp 1/1", mem_req, req_o.data_rvalid); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (mem_req !== 1'b0 || empty !== 1'b1) $display("FAIL midrst_fifo got mem_req=%b empty=%b exp 0/1", mem_req, empty); else n_pass++;
    n_total++; if (req_o.data_rvalid !== 1'b0 || unsup !== 1'b0) $display("FAIL midrst_flags got rvalid=%b unsup=%b exp 0/0", req_o.data_rvalid, unsup); else n_pass++;
    n_total++; if (mem_wdata !== 64'h0 || mem_addr !== 32'h0) $display("FAIL midrst_data got %h/%h exp 0", mem_addr, mem_wdata); else n_pass++;
    tick(); tick();
    n_total++; if (mem_req !== 1'b0 || req_o.data_rvalid !== 1'b0) $display("FAIL rst_hold got %b/%b exp 0/0", mem_req, req_o.data_rvalid); else n_pass++;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    mem_gnt  = 1'b0;
    page_off = 12'h000;
    req_i    = '0;
    test_reset();
    test_single_store();
    test_fill_full();
    test_push_pop();
    test_flush();
    test_hazard();
    test_read_reset();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/store_port_responder.md
# store_port_responder

Responder end of the D$ store port: accepts non-speculative write requests driven on a `dcache_req_i_t` port, grants them while buffer space is available, and holds them in a small in-order write FIFO. The FIFO drains one entry at a time to a simple write-only memory interface. It sits between a store-issuing unit and a backing SRAM or bus adapter, and exposes a page-offset hazard check so that loads can be held off until matching stores have drained.

## Interface
- `DEPTH`, default 4: number of FIFO entries; must be a power of 2 and ≥ 2.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `flush_i`  in  1  while high, no new grants are issued; the FIFO keeps draining.
- `req_port_i`  in  `dcache_req_i_t`  request port.
  - Used fields: `data_req`, `data_we`, `address_index`, `address_tag`, `data_wdata`, `data_be`, `data_size`.
  - `kill_req`, `tag_valid` and `data_id` are ignored; the tag is valid in the same cycle as the index.
- `req_port_o`  out  `dcache_req_o_t`  response port.
  - Drives `data_gnt` and `data_rvalid`.
  - `data_rdata` is always `'0`; all other fields are `'0`.
- `mem_req_o`  out  1  head entry valid, request to memory.
- `mem_gnt_i`  in  1  memory accepts the head entry this cycle.
- `mem_addr_o`  out  `DCACHE_TAG_WIDTH+DCACHE_INDEX_WIDTH`  `{address_tag, address_index}` of the head entry.
- `mem_wdata_o`  out  `riscv::XLEN`  head data.
- `mem_be_o`  out  `riscv::XLEN/8`  head byte enables.
- `mem_size_o`  out  2  head `data_size`.
- `page_offset_i`  in  12  load page offset to check.
- `page_offset_matches_o`  out  1  bits [11:3] of `page_offset_i` match a valid FIFO entry or the store being granted this cycle.
- `empty_o`  out  1  FIFO holds no entry.
- `unsupported_o`  out  1  sticky flag: a read request (`data_req & !data_we`) was seen.

## Operation
- **State**
  - Entry array: address, data, be, size, valid.
  - `rd_ptr_q` and `wr_ptr_q`, each `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`.
  - `cnt_q`, `$clog2(DEPTH)+1` bits.
  - `rvalid_q` and `unsupported_q`.
- **Grant**
  - `data_gnt = data_req & data_we & !flush_i & (cnt_q < DEPTH)`.
  - The grant is combinational. When the FIFO is full there is no pass-through, even if `mem_gnt_i` is high in the same cycle.
- **Push** (on grant): write the request fields at `wr_ptr_q`, set valid, increment `wr_ptr`.
- **Drain**
  - `mem_req_o = (cnt_q != 0)`; `mem_*` outputs are driven from entry `rd_ptr_q`.
  - On `mem_req_o & mem_gnt_i`: clear valid at `rd_ptr_q`, increment `rd_ptr`.
  - `mem_gnt_i` without `mem_req_o` is ignored.
- **Count**: `cnt_n = cnt_q + push - pop`. Push and pop in the same cycle leave the count unchanged. It never exceeds `DEPTH` and never underflows.
- **Ack**: `rvalid_q <= data_gnt`, so `data_rvalid` pulses exactly one cycle after each grant.
- **Reads**
  - Read requests are never granted and never acknowledged.
  - `unsupported_q` is set to 1 on the first read and stays set until reset.
- **Flush**
  - Suppresses grants only. Buffered entries are committed stores and are never discarded.
  - Pointers and count are unaffected.
- **Hazard check**
  - `page_offset_matches_o` is set when, for any i with `valid[i]`, `page_offset_i[11:3] == entry[i].address[11:3]`.
  - It is also set when `data_gnt` is high and `page_offset_i[11:3] == address_index[11:3]`.
  - It is purely combinational.
- **`empty_o`**: `cnt_q == 0`.

## Timing
- **Reset values**
  - All entries, pointers, `cnt_q`, `rvalid_q` and `unsupported_q` reset to 0.
  - Outputs after reset: `data_gnt`=0 (absent a request), `data_rvalid`=0, `mem_req_o`=0, `mem_*` data=0, `empty_o`=1, `unsupported_o`=0, `page_offset_matches_o`=0 (absent a grant).
- **Latency**
  - Grant in cycle N: the entry is visible on `mem_req_o` in cycle N+1 if the FIFO was empty.
  - `data_rvalid` rises in cycle N+1.
- **Throughput**: one grant and one drain per cycle sustained.
- **Full**
  - `cnt_q == DEPTH` gives `data_gnt` = 0.
  - A drain in cycle N re-enables grants in cycle N+1.
- **Wrap**: pointers roll from `DEPTH-1` to 0; order is strictly FIFO across the wrap.
- **Reset mid-operation**: buffered entries are lost; no `mem_req_o` and no `data_rvalid` are issued after reset asserts.
- **Flush timing**: flush rising in cycle N blocks the grant in N itself (combinational), while `mem_req_o` continues.

## Test plan
- **Single store**
  - Stimulus: one request, tag 0x12, index 0x0A8, data 0xDEADBEEF, be 0x0F, `mem_gnt_i`=1.
  - Required: gnt in C0, `rvalid` in C1, `mem_req_o` in C1 with `mem_addr_o={0x12,0x0A8}`, `empty_o`=1 in C2.
- **Fill to full**
  - Stimulus: `DEPTH`=4, `mem_gnt_i`=0, 5 back-to-back requests.
  - Required: 4 grants, 5th not granted.
  - Then raise `mem_gnt_i` for one cycle: the 5th is granted the following cycle, and drain order is 0,1,2,3,4 across the pointer wrap.
- **Simultaneous push and pop**
  - Stimulus: `cnt`=2, grant and `mem_gnt_i` in the same cycle.
  - Required: `cnt` stays 2, the head advances, data is intact.
- **Flush**
  - Stimulus: 3 entries buffered, `flush_i` high for 4 cycles with `data_req` held.
  - Required: no grants; all 3 entries drain; the grant resumes the cycle `flush_i` falls.
- **Hazard**
  - Stimulus: entry with index[11:3]=0x15; `page_offset_i`=0x0AF.
  - Required: `page_offset_matches_o`=1; with `page_offset_i`=0x0B0 it is 0; after the entry drains it is 0.
- **Read and reset**
  - Stimulus: a read request.
  - Required: no gnt, no `rvalid`, `unsupported_o`=1 and sticky.
  - Then assert `rst_ni`=0 with 2 entries buffered: all outputs return to reset values immediately.
